// File: rtl/shot_scheduler_if.sv
// Handshake between the shot scheduler (master) and the scenario FSM (slave).
interface shot_scheduler_if;
  logic scen_start;
  logic scen_idle;
  logic scen_done;

  modport master (output scen_start, input scen_idle, input scen_done);
  modport slave  (input scen_start, output scen_idle, output scen_done);
endinterface

// File: rtl/shot_scheduler.sv
// Repeats scenario shots with cooldown, shot counting and abort.
// Optional per-shot watchdog under `define SCHED_WATCHDOG_EN.
module shot_scheduler #(
  parameter int CNT_W  = 32,
  parameter int SHOT_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              arm,
  input  logic              abort,
  input  logic [SHOT_W-1:0] shot_count,
  input  logic [CNT_W-1:0]  cooldown_cycles,
  input  logic [CNT_W-1:0]  watchdog_cycles,
  shot_scheduler_if.master  scen,
  output logic              busy,
  output logic [SHOT_W-1:0] shots_done,
  output logic              run_done,
  output logic              aborted,
  output logic              fault,
  output logic [2:0]        sched_state
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRECHECK  = 3'd1,
    START     = 3'd2,
    WAIT_DONE = 3'd3,
    RELEASE   = 3'd4,
    COOLDOWN  = 3'd5,
    FAULT     = 3'd6
  } state_t;

  state_t            state_q, state_d;
  logic              start_q, start_d;
  logic [SHOT_W-1:0] shots_q, shots_d;
  logic              run_done_q, run_done_d;
  logic              aborted_q, aborted_d;
  logic              drain_q, drain_d;
  logic [SHOT_W-1:0] cfg_shots_q, cfg_shots_d;
  logic [CNT_W-1:0]  cfg_cd_q, cfg_cd_d;
  logic [CNT_W-1:0]  cd_cnt_q, cd_cnt_d;
`ifdef SCHED_WATCHDOG_EN
  logic [CNT_W-1:0]  cfg_wd_q, cfg_wd_d;
  logic [CNT_W-1:0]  wd_cnt_q, wd_cnt_d;
`else
  logic              unused_wd;
  assign unused_wd = ^watchdog_cycles;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      start_q     <= 1'b0;
      shots_q     <= '0;
      run_done_q  <= 1'b0;
      aborted_q   <= 1'b0;
      drain_q     <= 1'b0;
      cfg_shots_q <= '0;
      cfg_cd_q    <= '0;
      cd_cnt_q    <= '0;
`ifdef SCHED_WATCHDOG_EN
      cfg_wd_q    <= '0;
      wd_cnt_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      start_q     <= start_d;
      shots_q     <= shots_d;
      run_done_q  <= run_done_d;
      aborted_q   <= aborted_d;
      drain_q     <= drain_d;
      cfg_shots_q <= cfg_shots_d;
      cfg_cd_q    <= cfg_cd_d;
      cd_cnt_q    <= cd_cnt_d;
`ifdef SCHED_WATCHDOG_EN
      cfg_wd_q    <= cfg_wd_d;
      wd_cnt_q    <= wd_cnt_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    start_d     = start_q;
    shots_d     = shots_q;
    run_done_d  = 1'b0;
    aborted_d   = aborted_q;
    drain_d     = drain_q;
    cfg_shots_d = cfg_shots_q;
    cfg_cd_d    = cfg_cd_q;
    cd_cnt_d    = cd_cnt_q;
`ifdef SCHED_WATCHDOG_EN
    cfg_wd_d    = cfg_wd_q;
    wd_cnt_d    = wd_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        // abort in the same cycle drops the arm entirely
        if (arm && !abort) begin
          cfg_shots_d = shot_count;
          cfg_cd_d    = cooldown_cycles;
`ifdef SCHED_WATCHDOG_EN
          cfg_wd_d    = watchdog_cycles;
`endif
          shots_d     = '0;
          aborted_d   = 1'b0;
          drain_d     = 1'b0;
          if (shot_count == '0) run_done_d = 1'b1;
          else                  state_d    = PRECHECK;
        end
      end
      PRECHECK: begin
        if (abort) begin
          start_d = 1'b0;
          drain_d = 1'b1;
          state_d = RELEASE;
        end else if (scen.scen_idle) begin
          state_d = START;
        end
      end
      START: begin
        if (abort) begin
          start_d = 1'b0;
          drain_d = 1'b1;
          state_d = RELEASE;
        end else begin
          start_d = 1'b1;
`ifdef SCHED_WATCHDOG_EN
          wd_cnt_d = '0;
`endif
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        // abort beats a coincident scen_done: the shot is not counted
        if (abort) begin
          start_d = 1'b0;
          drain_d = 1'b1;
          state_d = RELEASE;
        end else if (scen.scen_done) begin
          start_d = 1'b0;
          if (shots_q != '1) shots_d = shots_q + SHOT_W'(1);
          state_d = RELEASE;
        end
`ifdef SCHED_WATCHDOG_EN
        else if (cfg_wd_q != '0 && wd_cnt_q == cfg_wd_q) begin
          start_d = 1'b0;
          state_d = FAULT;
        end else if (wd_cnt_q != '1) begin
          wd_cnt_d = wd_cnt_q + CNT_W'(1);
        end
`endif
      end
      RELEASE: begin
        start_d = 1'b0;
        if (abort) drain_d = 1'b1;
        if (scen.scen_idle) begin
          if (drain_q || abort) begin
            aborted_d = 1'b1;
            drain_d   = 1'b0;
            state_d   = IDLE;
          end else if (shots_q == cfg_shots_q) begin
            run_done_d = 1'b1;
            state_d    = IDLE;
          end else if (cfg_cd_q == '0) begin
            state_d = PRECHECK;
          end else begin
            cd_cnt_d = '0;
            state_d  = COOLDOWN;
          end
        end
      end
      COOLDOWN: begin
        if (abort) begin
          start_d = 1'b0;
          drain_d = 1'b1;
          state_d = RELEASE;
        end else if (cd_cnt_q == cfg_cd_q - CNT_W'(1)) begin
          state_d = PRECHECK;
        end else begin
          cd_cnt_d = cd_cnt_q + CNT_W'(1);
        end
      end
      FAULT: begin
        start_d = 1'b0;
        if (abort) begin
          aborted_d = 1'b1;
          state_d   = IDLE;
        end
      end
      default: begin
        start_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  assign scen.scen_start = start_q;
  assign busy            = (state_q != IDLE) && (state_q != FAULT);
  assign shots_done      = shots_q;
  assign run_done        = run_done_q;
  assign aborted         = aborted_q;
  assign sched_state     = state_q;
`ifdef SCHED_WATCHDOG_EN
  assign fault = (state_q == FAULT);
`else
  assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_shot_scheduler.sv
// Self-checking bench for shot_scheduler: table-driven runs, directed corner cases,
// and randomized runs against a behavioural scenario model and shot-counting reference.
module tb_shot_scheduler;
  localparam int CNT_W  = 32;
  localparam int SHOT_W = 16;

  logic              clock = 1'b0;
  logic              reset, arm, abort;
  logic [SHOT_W-1:0] shot_count;
  logic [CNT_W-1:0]  cooldown_cycles, watchdog_cycles;
  logic              busy, run_done, aborted, fault;
  logic [SHOT_W-1:0] shots_done;
  logic [2:0]        sched_state;

  shot_scheduler_if sif ();

  shot_scheduler #(.CNT_W(CNT_W), .SHOT_W(SHOT_W)) dut (
    .clock(clock), .reset(reset), .arm(arm), .abort(abort),
    .shot_count(shot_count), .cooldown_cycles(cooldown_cycles),
    .watchdog_cycles(watchdog_cycles), .scen(sif.master),
    .busy(busy), .shots_done(shots_done), .run_done(run_done),
    .aborted(aborted), .fault(fault), .sched_state(sched_state)
  );

  always #5 clock = ~clock;

  int tests = 0, fails = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // scenario model: leaves idle when start seen, done after lat cycles, idle 2 cycles after start drops
  bit model_en;
  int m_st, m_cnt, lat;
  // observation of the run
  int cyc, rises, falls, last_fall, gap_bad, seq_bad, rd_cnt, done_seen, rd_bad, cur_cd;
  bit prev_start;

  task automatic clear_mon();
    rises = 0; falls = 0; gap_bad = 0; seq_bad = 0; rd_cnt = 0; done_seen = 0; rd_bad = 0;
  endtask

  task automatic step();
    @(posedge clock); #1;
    cyc++;
    // a shot completes when the scheduler held start and saw done without abort at that edge
    if (prev_start && sif.scen_done && !abort && !reset) done_seen++;
    if (sif.scen_start && !prev_start) begin
      rises++;
      if (shots_done != SHOT_W'(rises - 1)) seq_bad++;
      if (falls > 0 && (cyc - last_fall < cur_cd || cyc - last_fall > cur_cd + 10)) gap_bad++;
    end
    if (!sif.scen_start && prev_start) begin
      falls++;
      last_fall = cyc;
    end
    if (run_done) begin
      rd_cnt++;
      if (busy || fault) rd_bad++;
    end
    prev_start = sif.scen_start;
    if (model_en) begin
      case (m_st)
        0: if (sif.scen_start) begin sif.scen_idle = 1'b0; m_cnt = 0; m_st = 1; end
        1: if (!sif.scen_start) begin m_cnt = 0; m_st = 3; end
           else begin
             m_cnt++;
             if (m_cnt >= lat) begin sif.scen_done = 1'b1; m_st = 2; end
           end
        2: if (!sif.scen_start) begin sif.scen_done = 1'b0; m_cnt = 0; m_st = 3; end
        default: begin
          m_cnt++;
          if (m_cnt >= 2) begin sif.scen_idle = 1'b1; m_st = 0; end
        end
      endcase
    end
  endtask

  task automatic pulse_arm();
    arm = 1'b1; step(); arm = 1'b0;
  endtask

  task automatic pulse_abort();
    abort = 1'b1; step(); abort = 1'b0;
  endtask

  task automatic model_reset();
    model_en = 1'b1; m_st = 0; m_cnt = 0;
    sif.scen_idle = 1'b1; sif.scen_done = 1'b0;
  endtask

  // one run; config inputs are scrambled after arm to prove they were latched
  task automatic run_cfg(input int shots, input int cd, input int l, input int abort_at,
                         output bit ab_issued, output bit to);
    shot_count = SHOT_W'(shots); cooldown_cycles = CNT_W'(cd); watchdog_cycles = CNT_W'(200);
    lat = l; cur_cd = cd; ab_issued = 1'b0; to = 1'b1;
    clear_mon();
    pulse_arm();
    shot_count = SHOT_W'($urandom_range(9, 1));
    cooldown_cycles = CNT_W'($urandom_range(40, 0));
    watchdog_cycles = CNT_W'($urandom_range(5, 1));
    for (int i = 0; i < 5000; i++) begin
      if (i == abort_at) begin pulse_abort(); ab_issued = 1'b1; end
      else step();
      if (rd_cnt > 0 || (ab_issued && aborted)) begin to = 1'b0; break; end
    end
    for (int i = 0; i < 4; i++) step();
  endtask

  task automatic check_normal(input string tag, input int exp_shots, input bit to);
    chk({tag, "_timeout"}, to, 0);
    chk({tag, "_rises"}, rises, exp_shots);
    chk({tag, "_shots_done"}, shots_done, exp_shots);
    chk({tag, "_run_done_pulses"}, rd_cnt, 1);
    chk({tag, "_busy_after"}, busy, 0);
    chk({tag, "_aborted"}, aborted, 0);
    chk({tag, "_cooldown_gaps"}, gap_bad, 0);
    chk({tag, "_shot_sequence"}, seq_bad, 0);
    chk({tag, "_run_done_excl"}, rd_bad, 0);
  endtask

  typedef struct {
    int shots; int cd; int lat; int exp_shots; int exp_rd;
  } vec_t;

  initial begin
    vec_t vecs[4];
    bit ab, to;
    int n;
    vecs[0] = '{3, 10, 50, 3, 1};
    vecs[1] = '{1, 0, 5, 1, 1};
    vecs[2] = '{4, 1, 3, 4, 1};
    vecs[3] = '{2, 25, 8, 2, 1};

    reset = 1'b1; arm = 1'b0; abort = 1'b0; shot_count = '0;
    cooldown_cycles = '0; watchdog_cycles = '0; cyc = 0; prev_start = 1'b0;
    model_reset(); clear_mon();
    for (int i = 0; i < 3; i++) step();
    chk("reset_state", sched_state, 0);
    chk("reset_start", sif.scen_start, 0);
    chk("reset_busy", busy, 0);
    chk("reset_shots", shots_done, 0);
    chk("reset_flags", {run_done, aborted, fault}, 0);
    reset = 1'b0;
    step();

    // table-driven complete runs
    foreach (vecs[i]) begin
      run_cfg(vecs[i].shots, vecs[i].cd, vecs[i].lat, -1, ab, to);
      check_normal($sformatf("vec%0d", i), vecs[i].exp_shots, to);
    end

    // zero-shot run: immediate pulse, nothing started
    shot_count = '0; clear_mon();
    pulse_arm();
    chk("zero_run_done", run_done, 1);
    chk("zero_busy", busy, 0);
    step();
    chk("zero_run_done_pulse", run_done, 0);
    for (int i = 0; i < 10; i++) step();
    chk("zero_rises", rises, 0);
    chk("zero_shots", shots_done, 0);

    // scenario not idle: hold in PRECHECK
    model_en = 1'b0; sif.scen_idle = 1'b0; shot_count = SHOT_W'(1);
    cooldown_cycles = '0; watchdog_cycles = '0; clear_mon(); lat = 4;
    pulse_arm();
    n = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (sched_state != 3'd1 || sif.scen_start) n++;
    end
    chk("precheck_hold", n, 0);
    sif.scen_idle = 1'b1;
    step();
    chk("precheck_start_early", sif.scen_start, 0);
    step();
    chk("precheck_start_rise", sif.scen_start, 1);
    model_en = 1'b1; m_st = 0;
    for (int i = 0; i < 200 && rd_cnt == 0; i++) step();
    chk("precheck_run_done", rd_cnt, 1);

    // abort during the second shot
    lat = 50; cur_cd = 3;
    shot_count = SHOT_W'(5); cooldown_cycles = CNT_W'(3); clear_mon();
    pulse_arm();
    for (int i = 0; i < 2000 && rises < 2; i++) step();
    chk("abort_reach_2nd", rises, 2);
    for (int i = 0; i < 10; i++) step();
    pulse_abort();
    chk("abort_start_fall", sif.scen_start, 0);
    for (int i = 0; i < 50 && !aborted; i++) step();
    chk("abort_sticky", aborted, 1);
    chk("abort_shots", shots_done, 1);
    chk("abort_no_run_done", rd_cnt, 0);
    chk("abort_busy", busy, 0);
    for (int i = 0; i < 5; i++) step();
    run_cfg(2, 0, 4, -1, ab, to);
    check_normal("rearm", 2, to);

    // watchdog
    model_en = 1'b0; sif.scen_idle = 1'b1; sif.scen_done = 1'b0;
    shot_count = SHOT_W'(1); cooldown_cycles = '0; watchdog_cycles = CNT_W'(100);
    clear_mon();
    pulse_arm();
    for (int i = 0; i < 20 && rises == 0; i++) step();
    n = 0;
`ifdef SCHED_WATCHDOG_EN
    // start is held while the counter runs 0..watchdog_cycles, then FAULT
    while (!fault && n < 500) begin step(); n++; end
    chk("wd_latency", n, 101);
    chk("wd_start_low", sif.scen_start, 0);
    pulse_arm();
    chk("wd_arm_ignored", sched_state, 6);
    chk("wd_fault_busy", {fault, busy}, 2);
    pulse_abort();
    chk("wd_abort_exit", {fault, aborted, sched_state}, 5'b01000);
    watchdog_cycles = '0; clear_mon();
    pulse_arm();
    n = 0;
    for (int i = 0; i < 10000; i++) begin step(); if (fault) n++; end
    chk("wd_disabled_fault", n, 0);
    chk("wd_disabled_start", sif.scen_start, 1);
`else
    for (int i = 0; i < 300; i++) begin step(); if (fault || !sif.scen_start) n++; end
    chk("nowd_waits", n, 0);
`endif
    pulse_abort();
    for (int i = 0; i < 20 && busy; i++) step();
    chk("wd_drain_aborted", {busy, aborted, fault}, 3'b010);
    model_reset();

    // arm with abort in IDLE: nothing happens, aborted untouched
    shot_count = '0; clear_mon();
    arm = 1'b1; abort = 1'b1; step(); arm = 1'b0; abort = 1'b0;
    for (int i = 0; i < 3; i++) step();
    chk("armabort_idle", {busy, sched_state}, 0);
    chk("armabort_no_latch", rd_cnt, 0);
    chk("armabort_aborted_kept", aborted, 1);

    // synchronous reset mid-WAIT_DONE
    lat = 50; cur_cd = 2;
    shot_count = SHOT_W'(3); cooldown_cycles = CNT_W'(2); clear_mon();
    pulse_arm();
    for (int i = 0; i < 1000 && rises < 2; i++) step();
    for (int i = 0; i < 5; i++) step();
    chk("rst_pre_shots", shots_done, 1);
    reset = 1'b1; step(); reset = 1'b0;
    chk("rst_mid_state", sched_state, 0);
    chk("rst_mid_outputs", {sif.scen_start, busy, run_done, aborted, fault}, 0);
    chk("rst_mid_shots", shots_done, 0);
    for (int i = 0; i < 6; i++) step();

    // randomized runs, some with an abort at a random point
    for (int k = 0; k < 8; k++) begin
      int s, c, l, at;
      s = $urandom_range(4, 1); c = $urandom_range(15, 0); l = $urandom_range(20, 1);
      at = ($urandom_range(1, 0) == 1) ? int'($urandom_range(200, 2)) : -1;
      run_cfg(s, c, l, at, ab, to);
      if (ab && rd_cnt == 0) begin
        chk($sformatf("rnd%0d_timeout", k), to, 0);
        chk($sformatf("rnd%0d_aborted", k), aborted, 1);
        chk($sformatf("rnd%0d_shots", k), shots_done, done_seen);
        chk($sformatf("rnd%0d_no_run_done", k), rd_cnt, 0);
        chk($sformatf("rnd%0d_busy", k), busy, 0);
      end else begin
        check_normal($sformatf("rnd%0d", k), s, to);
      end
      for (int i = 0; i < 4; i++) step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
